serial_subtractor_ctrl: RTL and testbench

//  Bit-serial WIDTH-bit subtractor built from a single 1-bit full-subtractor cell.

---
 rtl/serial_subtractor_ctrl_pkg.sv | 11 +
 rtl/serial_subtractor_ctrl_fs_cell.sv | 13 +
 rtl/serial_subtractor_ctrl.sv | 106 ++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_ctrl_pkg;

    // Encoding 2'd3 is unused; the controller falls back to IDLE from it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_ctrl_fs_cell.sv
// Purely combinational 1-bit full subtractor: diff = a - b - bin, bout on underflow.
module fs_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one fs_cell sequenced LSB->MSB, borrow kept in a flop.
module serial_subtractor_ctrl
    import serial_subtractor_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] diff_r;
    logic [WIDTH-1:0] diff_work;
    logic             brw;
    logic             cell_d;
    logic             cell_bout;

    fs_cell u_cell (
        .a    (a_r[cnt]),
        .b    (b_r[cnt]),
        .bin  (brw),
        .diff (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_IDX) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Partial result with the current bit merged in.
    always_comb begin
        diff_work      = diff_r;
        diff_work[cnt] = cell_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            a_r    <= '0;
            b_r    <= '0;
            diff_r <= '0;
            brw    <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        brw    <= bin;
                        cnt    <= '0;
                        diff_r <= '0;
                    end
                end
                RUN: begin
                    diff_r <= diff_work;
                    brw    <= cell_bout;
                    // NOTE: diff/bout load only on the final bit so partial results never appear.
                    if (cnt == LAST_IDX) begin
                        diff <= diff_work;
                        bout <= cell_bout;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl (WIDTH=8): vector table, corner grid, random ops.
module tb_serial_subtractor_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] last_d;
    logic             last_bo;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             bin;
        logic [WIDTH-1:0] d;
        logic             bo;
    } vec_t;

    vec_t             vecs[6];
    logic [WIDTH-1:0] corners[6];

    serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Unsigned a - b - bin: low WIDTH bits are diff, bit WIDTH is the borrow.
    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic bi);
        int r;
        r = int'(x) - int'(y) - int'(bi);
        return (WIDTH+1)'(r + (1 << (WIDTH + 1)));
    endfunction

    // One full operation from IDLE; returns to IDLE so the next call is back-to-back.
    task automatic do_op(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic bi, input logic [WIDTH-1:0] ed, input logic eb);
        int   lat;
        int   busy_cnt;
        logic got;
        logic hold_ok;
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); bin = 1'($urandom);
        lat = 0; busy_cnt = 0; got = 1'b0; hold_ok = 1'b1;
        while (!got && lat < 4 * WIDTH) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                if (diff !== last_d || bout !== last_bo) hold_ok = 1'b0;
                @(posedge clk); #1;
                lat++;
            end
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
        check({name, "_latency"}, 32'(lat), 32'(WIDTH));
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH));
        check({name, "_hold"}, 32'(hold_ok), 32'd1);
        check({name, "_diff"}, 32'(diff), 32'(ed));
        check({name, "_bout"}, 32'(bout), 32'(eb));
        last_d  = ed;
        last_bo = eb;
        @(posedge clk); #1;
        check({name, "_done_pulse"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        logic [WIDTH:0] r;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rbi;
        int               n_done;
        logic [WIDTH-1:0] cap_d;
        logic             cap_bo;

        vecs[0] = '{8'd5,   8'd3,   1'b0, 8'd2,   1'b0};
        vecs[1] = '{8'd0,   8'd1,   1'b0, 8'hFF,  1'b1};
        vecs[2] = '{8'd0,   8'd0,   1'b1, 8'hFF,  1'b1};
        vecs[3] = '{8'hFF,  8'hFF,  1'b0, 8'h00,  1'b0};
        vecs[4] = '{8'hFF,  8'h00,  1'b1, 8'hFE,  1'b0};
        vecs[5] = '{8'h80,  8'h7F,  1'b1, 8'h00,  1'b0};
        corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
        corners[3] = 8'h80; corners[4] = 8'hFE; corners[5] = 8'hFF;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        last_d = '0; last_bo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({busy, done, diff, bout}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_reset", 32'({busy, done}), 32'd0);

        for (int i = 0; i < 6; i++)
            do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo);

        // Start pulsed during RUN must be dropped, not queued.
        @(negedge clk);
        a = 8'd9; b = 8'd4; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = 8'd1; b = 8'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0; cap_d = '0; cap_bo = 1'b0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            if (done) begin
                if (n_done == 0) begin
                    cap_d  = diff;
                    cap_bo = bout;
                end
                n_done++;
            end
            @(posedge clk); #1;
        end
        check("ignore_start_dones", 32'(n_done), 32'd1);
        check("ignore_start_diff", 32'(cap_d), 32'd5);
        check("ignore_start_bout", 32'(cap_bo), 32'd0);
        last_d = 8'd5; last_bo = 1'b0;

        // Reset in the middle of RUN abandons the operation.
        @(negedge clk);
        a = 8'h20; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrun_reset_outputs", 32'({busy, done, diff, bout}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(posedge clk); #1;
            if (done || busy) n_done++;
        end
        check("midrun_reset_no_done", 32'(n_done), 32'd0);
        last_d = '0; last_bo = 1'b0;
        do_op("after_reset", 8'd7, 8'd7, 1'b0, 8'd0, 1'b0);

        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                for (int k = 0; k < 2; k++) begin
                    r = ref_sub(corners[i], corners[j], 1'(k));
                    do_op($sformatf("corner_%0h_%0h_%0d", corners[i], corners[j], k),
                          corners[i], corners[j], 1'(k), r[WIDTH-1:0], r[WIDTH]);
                end

        for (int i = 0; i < 1500; i++) begin
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            rbi = 1'($urandom);
            r   = ref_sub(ra, rb, rbi);
            do_op($sformatf("rand%0d", i), ra, rb, rbi, r[WIDTH-1:0], r[WIDTH]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
